iic_byte_master: RTL

Byte-level I2C master for the Nios II system. It replaces software bit-banging of the SDA/SCL PIO pins with a hardware engine that generates START, 8 data bits, ACK, and STOP on open-drain `sda_port`/`scl_port`. It sits on the Avalon-MM bus as a 4-word slave and connects directly to the board's I2C pins (audio codec / config bus).

---
 rtl/iic_master_pkg.sv | 39 +++
 rtl/iic_quarter_tick.sv | 50 +++++
 rtl/iic_byte_master.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/iic_master_pkg.sv
// Shared types and constants for the byte-level I2C master.
// Used by iic_quarter_tick and iic_byte_master.
package iic_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BITS,
        ST_ACK,
        ST_STOP
    } state_e;

    typedef enum logic [1:0] {
        PH_Q0,
        PH_Q1,
        PH_Q2,
        PH_Q3
    } phase_e;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CMD    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_CLKDIV = 2'd3;

    localparam int CMD_START = 0;
    localparam int CMD_STOP  = 1;
    localparam int CMD_RD    = 2;
    localparam int CMD_NACK  = 3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_ACK_ERR = 1;
    localparam int STAT_IRQ     = 2;

    // A programmed quarter length of 0 runs as 1.
    function automatic logic [15:0] eff_quarter(input logic [15:0] q);
        return (q == 16'd0) ? 16'd1 : q;
    endfunction

endpackage

// File: rtl/iic_quarter_tick.sv
// Quarter-SCL-period divider: 1-cycle tick every Q clocks, 2-bit phase count.
// hold_i freezes the count while a slave stretches SCL.
module iic_quarter_tick
    import iic_master_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear_i,
    input  logic        run_i,
    input  logic        hold_i,
    input  logic [15:0] quarter_i,
    output logic        tick_o,
    output logic [1:0]  phase_o
);

    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  phase_q, phase_d;
    logic [15:0] last_cnt;

    assign last_cnt = eff_quarter(quarter_i) - 16'd1;
    assign tick_o   = run_i && !hold_i && (cnt_q == last_cnt);
    assign phase_o  = phase_q;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (clear_i) begin
            cnt_d   = 16'd0;
            phase_d = 2'd0;
        end else if (run_i && !hold_i) begin
            if (cnt_q == last_cnt) begin
                cnt_d   = 16'd0;
                phase_d = phase_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= 16'd0;
            phase_q <= 2'd0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/iic_byte_master.sv
// Avalon-MM byte-level I2C master: START, 8 bits, ACK, STOP on open-drain pins.
// Define IIC_BYTE_MASTER_IRQ_EN to add the irq output and the irq_pend status bit.
module iic_byte_master
    import iic_master_pkg::*;
#(
    parameter int CLKDIV_RESET = 125
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    inout  wire         scl_port,
    inout  wire         sda_port
`ifdef IIC_BYTE_MASTER_IRQ_EN
    ,
    output logic        irq
`endif
);

    state_e      state_q;
    logic        busy_q, ack_err_q;
    logic [7:0]  tx_byte_q, rx_byte_q, sh_q;
    logic [2:0]  bit_cnt_q;
    logic [15:0] clkdiv_q;
    logic        cmd_stop_q, cmd_rd_q, cmd_nack_q;
    logic        scl_pull_q, sda_pull_q;
    logic [31:0] readdata_q;
    logic        irq_pend;

    logic        wr, launch, tick, hold, tick_clear, xfer_done;
    logic        scl_in, sda_in;
    logic [1:0]  phase_raw;
    phase_e      phase;
    logic        unused_bits;

    assign scl_port = scl_pull_q ? 1'b0 : 1'bz;
    assign sda_port = sda_pull_q ? 1'b0 : 1'bz;
    assign scl_in   = scl_port;
    assign sda_in   = sda_port;

    assign wr     = chipselect && !write_n;
    assign launch = wr && (address == ADDR_CMD) && !busy_q;
    assign phase  = phase_e'(phase_raw);

    // Stretching applies only to quarters where the master has just released SCL.
    assign hold = busy_q && (phase == PH_Q1) && (state_q != ST_START) && !scl_in;
    assign tick_clear = launch || (tick && (state_q == ST_START) && (phase == PH_Q2));
    assign xfer_done  = tick && (((state_q == ST_ACK) && (phase == PH_Q3) && !cmd_stop_q) ||
                                 ((state_q == ST_STOP) && (phase == PH_Q2)));
    assign unused_bits = &{1'b0, writedata[31:16]};

    iic_quarter_tick u_tick (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_i   (tick_clear),
        .run_i     (busy_q),
        .hold_i    (hold),
        .quarter_i (clkdiv_q),
        .tick_o    (tick),
        .phase_o   (phase_raw)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            tx_byte_q  <= 8'd0;
            rx_byte_q  <= 8'd0;
            sh_q       <= 8'd0;
            bit_cnt_q  <= 3'd0;
            clkdiv_q   <= 16'(CLKDIV_RESET);
            cmd_stop_q <= 1'b0;
            cmd_rd_q   <= 1'b0;
            cmd_nack_q <= 1'b0;
            scl_pull_q <= 1'b0;
            sda_pull_q <= 1'b0;
        end else begin
            if (wr && (address == ADDR_DATA))
                tx_byte_q <= writedata[7:0];
            if (wr && (address == ADDR_CLKDIV) && !busy_q)
                clkdiv_q <= writedata[15:0];
            if (xfer_done)
                busy_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        busy_q     <= 1'b1;
                        ack_err_q  <= 1'b0;
                        sh_q       <= tx_byte_q;
                        bit_cnt_q  <= 3'd0;
                        cmd_stop_q <= writedata[CMD_STOP];
                        cmd_rd_q   <= writedata[CMD_RD];
                        cmd_nack_q <= writedata[CMD_NACK];
                        if (writedata[CMD_START]) begin
                            state_q    <= ST_START;
                            scl_pull_q <= 1'b0;
                            sda_pull_q <= 1'b0;
                        end else begin
                            state_q    <= ST_BITS;
                            scl_pull_q <= 1'b1;
                            sda_pull_q <= !writedata[CMD_RD] && !tx_byte_q[7];
                        end
                    end
                end
                ST_START: begin
                    if (tick) begin
                        case (phase)
                            PH_Q0:   sda_pull_q <= 1'b1;
                            PH_Q1:   scl_pull_q <= 1'b1;
                            default: begin
                                state_q    <= ST_BITS;
                                sda_pull_q <= !cmd_rd_q && !sh_q[7];
                            end
                        endcase
                    end
                end
                ST_BITS: begin
                    if (tick) begin
                        case (phase)
                            PH_Q0: scl_pull_q <= 1'b0;
                            // Shifting at the sample point leaves the next bit to send in sh_q[7].
                            PH_Q1: sh_q <= {sh_q[6:0], sda_in};
                            PH_Q2: scl_pull_q <= 1'b1;
                            PH_Q3: begin
                                if (bit_cnt_q == 3'd7) begin
                                    state_q    <= ST_ACK;
                                    sda_pull_q <= cmd_rd_q && !cmd_nack_q;
                                end else begin
                                    bit_cnt_q  <= bit_cnt_q + 3'd1;
                                    sda_pull_q <= !cmd_rd_q && !sh_q[7];
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_ACK: begin
                    if (tick) begin
                        case (phase)
                            PH_Q0: scl_pull_q <= 1'b0;
                            PH_Q1: if (!cmd_rd_q) ack_err_q <= sda_in;
                            PH_Q2: scl_pull_q <= 1'b1;
                            PH_Q3: begin
                                if (cmd_rd_q)
                                    rx_byte_q <= sh_q;
                                if (cmd_stop_q) begin
                                    state_q    <= ST_STOP;
                                    sda_pull_q <= 1'b1;
                                end else begin
                                    state_q    <= ST_IDLE;
                                    sda_pull_q <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        case (phase)
                            PH_Q0:   scl_pull_q <= 1'b0;
                            PH_Q1:   sda_pull_q <= 1'b0;
                            default: state_q <= ST_IDLE;
                        endcase
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef IIC_BYTE_MASTER_IRQ_EN
    logic irq_pend_q;

    // Completion wins over a same-cycle clear so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            irq_pend_q <= 1'b0;
        else if (xfer_done)
            irq_pend_q <= 1'b1;
        else if (wr && (address == ADDR_STATUS) && writedata[STAT_IRQ])
            irq_pend_q <= 1'b0;
    end

    assign irq_pend = irq_pend_q;
    assign irq      = irq_pend_q;
`else
    assign irq_pend = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_q <= 32'd0;
        end else begin
            case (address)
                ADDR_DATA:   readdata_q <= {24'd0, rx_byte_q};
                ADDR_STATUS: readdata_q <= {29'd0, irq_pend, ack_err_q, busy_q};
                ADDR_CLKDIV: readdata_q <= {16'd0, clkdiv_q};
                default:     readdata_q <= 32'd0;
            endcase
        end
    end

    assign readdata = readdata_q;

endmodule
